// File: rtl/loadq_entry_mp.sv
// Load-queue entry with multiple issue ports, exponential replay backoff,
// a store-blocked wait state and a saturating replay counter with hang flag.
module loadq_entry_mp #(
   parameter int ID_W      = 4,
   parameter int ADDR_W    = 64,
   parameter int PDST_W    = 7,
   parameter int ROBID_W   = 6,
   parameter int STQ_N     = 8,
   parameter int NUM_ISS   = 2,
   parameter int BACKOFF_W = 3,
   parameter int REPLAY_W  = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [ID_W-1:0]           id,
   input  logic                      nuke_valid,
   input  logic [STQ_N-1:0]          stq_e_valid,
   input  logic                      alloc,
   input  logic [ROBID_W-1:0]        alloc_robid,
   input  logic [NUM_ISS-1:0]        iss_valid,
   input  logic [NUM_ISS*ID_W-1:0]   iss_ldqid,
   input  logic [NUM_ISS*ADDR_W-1:0] iss_src1,
   input  logic [NUM_ISS*ADDR_W-1:0] iss_src2,
   input  logic [NUM_ISS*PDST_W-1:0] iss_pdst,
   output logic                      e_valid,
   output logic [ROBID_W-1:0]        e_robid,
   output logic                      pipe_req,
   output logic [ADDR_W-1:0]         pipe_req_addr,
   output logic [PDST_W-1:0]         pipe_req_pdst,
   output logic [STQ_N-1:0]          pipe_req_elders,
   input  logic                      pipe_gnt,
   input  logic                      act_valid,
   input  logic                      act_is_load,
   input  logic [ID_W-1:0]           act_id,
   input  logic                      act_complete,
   input  logic                      act_recycle,
   input  logic                      act_stq_block,
   output logic [REPLAY_W-1:0]       e_replay_cnt,
   output logic                      e_hang
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PDG_ISS,
      ST_REQ_PIPE,
      ST_PDG_PIPE,
      ST_BACKOFF,
      ST_WAIT_STQ
   } state_t;

   state_t                 state_q, state_d;
   logic [ROBID_W-1:0]     robid_q, robid_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [PDST_W-1:0]      pdst_q, pdst_d;
   logic [STQ_N-1:0]       elders_q, elders_d;
   logic [REPLAY_W-1:0]    replay_q, replay_d;
   logic [BACKOFF_W-1:0]   backoff_q, backoff_d;

   logic [NUM_ISS-1:0]     iss_hits;
   logic                   iss_hit;
   logic [ADDR_W-1:0]      iss_addr;
   logic [PDST_W-1:0]      iss_pdst_sel;
   logic [BACKOFF_W-1:0]   backoff_load;
   logic                   act_hit;

   assign act_hit = act_valid && act_is_load && (act_id == id);

   // Pick the lowest-numbered issue port targeting this entry and form its address
   always_comb begin
      iss_hits     = '0;
      iss_hit      = 1'b0;
      iss_addr     = '0;
      iss_pdst_sel = '0;
      for (int p = NUM_ISS - 1; p >= 0; p--) begin
         if (iss_valid[p] && (iss_ldqid[p*ID_W +: ID_W] == id)) begin
            iss_hits[p]  = 1'b1;
            iss_hit      = 1'b1;
            iss_addr     = iss_src1[p*ADDR_W +: ADDR_W] + iss_src2[p*ADDR_W +: ADDR_W];
            iss_pdst_sel = iss_pdst[p*PDST_W +: PDST_W];
         end
      end
   end

   // Backoff reload is 2^min(replays, BACKOFF_W) - 1 so the dwell doubles per replay
   always_comb begin
      backoff_load = '1;
      for (int i = 0; i < BACKOFF_W; i++) begin
         if (replay_q == REPLAY_W'(i)) begin
            backoff_load = BACKOFF_W'((1 << i) - 1);
         end
      end
   end

   // Next-state and next-value logic; a nuke overrides everything and drops any alloc
   always_comb begin
      state_d   = state_q;
      robid_d   = robid_q;
      addr_d    = addr_q;
      pdst_d    = pdst_q;
      elders_d  = elders_q & stq_e_valid;
      replay_d  = replay_q;
      backoff_d = backoff_q;
      if (nuke_valid) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (alloc) begin
                  state_d  = ST_PDG_ISS;
                  robid_d  = alloc_robid;
                  replay_d = '0;
                  elders_d = stq_e_valid;
               end
            end
            ST_PDG_ISS: begin
               if (iss_hit) begin
                  state_d = ST_REQ_PIPE;
                  addr_d  = iss_addr;
                  pdst_d  = iss_pdst_sel;
               end
            end
            ST_REQ_PIPE: begin
               if (pipe_gnt) state_d = ST_PDG_PIPE;
            end
            ST_PDG_PIPE: begin
               if (act_hit) begin
                  if (act_complete) begin
                     state_d = ST_IDLE;
                  end else if (act_recycle) begin
                     if (replay_q != '1) replay_d = replay_q + 1'b1;
                     if (act_stq_block) begin
                        state_d = ST_WAIT_STQ;
                     end else begin
                        state_d   = ST_BACKOFF;
                        backoff_d = backoff_load;
                     end
                  end
               end
            end
            ST_BACKOFF: begin
               if (backoff_q == '0) state_d = ST_REQ_PIPE;
               else                 backoff_d = backoff_q - 1'b1;
            end
            ST_WAIT_STQ: begin
               if (elders_q == '0) state_d = ST_REQ_PIPE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and captured-field registers with asynchronous clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         robid_q   <= '0;
         addr_q    <= '0;
         pdst_q    <= '0;
         elders_q  <= '0;
         replay_q  <= '0;
         backoff_q <= '0;
      end else begin
         state_q   <= state_d;
         robid_q   <= robid_d;
         addr_q    <= addr_d;
         pdst_q    <= pdst_d;
         elders_q  <= elders_d;
         replay_q  <= replay_d;
         backoff_q <= backoff_d;
      end
   end

   assign e_valid         = (state_q != ST_IDLE);
   assign pipe_req        = (state_q == ST_REQ_PIPE);
   assign e_robid         = robid_q;
   assign pipe_req_addr   = addr_q;
   assign pipe_req_pdst   = pdst_q;
   assign pipe_req_elders = elders_q;
   assign e_replay_cnt    = replay_q;
   assign e_hang          = (replay_q == '1);

   a_alloc_when_free: assert property (@(posedge clk) disable iff (!reset_n)
      (alloc && !nuke_valid) |-> !e_valid);
   a_issue_when_pending: assert property (@(posedge clk) disable iff (!reset_n)
      ((|iss_hits) && !nuke_valid) |-> (state_q == ST_PDG_ISS));
   a_single_issue_hit: assert property (@(posedge clk) disable iff (!reset_n)
      $onehot0(iss_hits));

endmodule
